// File: rtl/shift_reg_univ.sv
// shift_reg_univ: w-bit universal shift register
// with a shift counter and one-cycle frame strobe.
module shift_reg_univ #(
  parameter int w = 8,
  localparam int cw = $clog2(w)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic          ser_in_msb,
  input  logic          ser_in_lsb,
  input  logic [w-1:0]  par_in,
  output logic [w-1:0]  par_out,
  output logic          ser_out_lsb,
  output logic          ser_out_msb,
  output logic [cw-1:0] shift_cnt,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    ROR  = 3'd3,
    ROL  = 3'd4,
    LOAD = 3'd5,
    CLR  = 3'd6,
    ASR  = 3'd7
  } mode_e;

  localparam logic [cw-1:0] cnt_last = cw'(w - 1);

  mode_e         m;
  logic [w-1:0]  q;
  logic [w-1:0]  q_nxt;
  logic [cw-1:0] cnt;
  logic          fd;
  logic          is_shift;
  logic          is_clr;
  logic          wrap;

  assign m    = mode_e'(mode);
  assign wrap = (cnt == cnt_last);

  always_comb begin
    q_nxt    = q;
    is_shift = 1'b0;
    is_clr   = 1'b0;
    unique case (m)
      HOLD: ;
      SHR: begin
        q_nxt    = {ser_in_msb, q[w-1:1]};
        is_shift = 1'b1;
      end
      SHL: begin
        q_nxt    = {q[w-2:0], ser_in_lsb};
        is_shift = 1'b1;
      end
      ROR: begin
        q_nxt    = {q[0], q[w-1:1]};
        is_shift = 1'b1;
      end
      ROL: begin
        q_nxt    = {q[w-2:0], q[w-1]};
        is_shift = 1'b1;
      end
      LOAD: begin
        q_nxt  = par_in;
        is_clr = 1'b1;
      end
      CLR: begin
        q_nxt  = '0;
        is_clr = 1'b1;
      end
      ASR: begin
        q_nxt    = {q[w-1], q[w-1:1]};
        is_shift = 1'b1;
      end
    endcase
  end

  // Counter wraps at w-1, so non-power-of-two widths frame correctly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= '0;
      cnt <= '0;
      fd  <= 1'b0;
    end else if (!en) begin
      fd <= 1'b0;
    end else begin
      q  <= q_nxt;
      fd <= is_shift && wrap;
      if (is_clr)
        cnt <= '0;
      else if (is_shift)
        cnt <= wrap ? '0 : cnt + cw'(1);
    end
  end

  assign par_out     = q;
  assign ser_out_lsb = q[0];
  assign ser_out_msb = q[w-1];
  assign shift_cnt   = cnt;
  assign frame_done  = fd;

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register. It generalises the one-direction serial-in shift register to eight operating modes: hold, both shift directions, both rotate directions, arithmetic shift, parallel load and clear. A built-in shift counter raises a one-cycle frame strobe after every w shift operations. It serves the lab FSM and datapath exercises as a serial/parallel converter, for example deserialising a UART-like bit stream or serialising a parallel word onto a pin.

Parameters:
w, 8, register width in bits; legal range 2..32
cw, derived ($clog2(w)), width of shift_cnt; not overridable

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
en  input  1  operation enable; when 0 the block holds all state and frame_done is 0
mode  input  3  operation select (encoding below)
ser_in_msb  input  1  serial input entering at bit w-1 (right shift)
ser_in_lsb  input  1  serial input entering at bit 0 (left shift)
par_in  input  w  parallel load data
par_out  output  w  register contents
ser_out_lsb  output  1  par_out[0], combinational
ser_out_msb  output  1  par_out[w-1], combinational
shift_cnt  output  cw  shift operations performed in the current frame, 0..w-1
frame_done  output  1  registered one-cycle pulse marking completion of w shift operations

Behaviour:
- Reset (async, active-high): par_out=0, shift_cnt=0, frame_done=0. Asserting reset mid-frame aborts the frame with no frame_done.
- All state updates on posedge clk, and only when en=1. When en=0, state holds and frame_done=0 on the next edge.
- mode encoding (applies when en=1):
  - 0 HOLD: no change.
  - 1 SHR: par_out <= {ser_in_msb, par_out[w-1:1]}.
  - 2 SHL: par_out <= {par_out[w-2:0], ser_in_lsb}.
  - 3 ROR: par_out <= {par_out[0], par_out[w-1:1]}.
  - 4 ROL: par_out <= {par_out[w-2:0], par_out[w-1]}.
  - 5 LOAD: par_out <= par_in.
  - 6 CLEAR: par_out <= 0.
  - 7 ASR: par_out <= {par_out[w-1], par_out[w-1:1]}.
- Shift operations are modes 1, 2, 3, 4 and 7.
- Frame counter:
  - Each enabled shift operation increments shift_cnt.
  - When shift_cnt==w-1 and a shift occurs, shift_cnt wraps to 0 and frame_done <= 1 for exactly that one cycle.
  - Otherwise frame_done <= 0.
  - w need not be a power of two; wrap is at w-1, not at 2^cw-1.
- LOAD and CLEAR reset shift_cnt to 0 and drive frame_done=0. HOLD leaves shift_cnt unchanged.
- Latency: par_out, shift_cnt and frame_done all reflect an operation one cycle after the sampling edge. ser_out_* follow par_out with no extra delay.
- Mode changes mid-frame are legal: the counter keeps counting shifts regardless of direction.
- Back-to-back frames: continuous shifting produces frame_done every w cycles with no gap cycle.
- Undefined/X on mode is not supported; behaviour for X is unspecified.

Test Plan:
- Reset mid-frame: w=8; apply 3 SHR operations, then assert reset asynchronously between edges -> par_out=0 and shift_cnt=0 immediately, without waiting for an edge; no frame_done is seen.
- Deserialise: w=8, mode=SHR, en=1; drive ser_in_msb with 1,0,1,1,0,0,1,0 over 8 cycles -> par_out=8'b01001101; frame_done high only on cycle 8; shift_cnt sequence 1..7 then 0.
- Load and serialise: LOAD par_in=8'hA5, then 8 cycles of SHL with ser_in_lsb=0 -> ser_out_msb sequence 1,0,1,0,0,1,0,1; par_out=0 afterwards; frame_done on the 8th shift.
- Rotate and arithmetic: LOAD 8'h81; ROR -> 8'hC0; ROL -> 8'h81; ASR -> 8'hC0; ASR -> 8'hE0; shift_cnt=4 after these 4 shifts.
- Enable gating: during SHR with en toggling 1,0,1,0,... -> par_out and shift_cnt change only on en=1 edges; frame_done appears after 8 enabled shifts, i.e. 16 cycles.
- Counter clear and non-power-of-two width: w=5; 3 shifts, then CLEAR -> shift_cnt=0, par_out=0; then 5 SHR -> frame_done on the 5th; 5 more shifts -> second frame_done exactly 5 cycles later.
